dfm_gate_sched: RTL and testbench
=================================

# dfm_gate_sched

Round-robin gate scheduler that shares one counting datapath between up to N_CH frequency-measurement channels. It takes the per-channel enables raised by the power-up gate sequencer and picks the next enabled channel. For that channel it issues a one-cycle counter clear, then holds the gate open for a programmable number of clock cycles, then presents the result slot to the downstream reader with a valid/ready handshake. It sits between the startup gate-enable logic and the shared counter/latch datapath.

## Interface
- N_CH, 5, number of channels (2..8)
- GATE_W, 32, width of gate-time counter
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- chan_en_i  in  N_CH  per-channel enable (bit k = channel k may be measured)
- gate_time_i  in  GATE_W  gate length in clk_i cycles; sampled at CLEAR
- res_ready_i  in  1  downstream accepts result
- sel_o  out  $clog2(N_CH)  channel currently owning the datapath
- clr_o  out  1  clear shared counters (one-cycle pulse)
- gate_o  out  1  gate open, datapath counts
- res_valid_o  out  1  result for channel sel_o is ready
- abort_o  out  1  one-cycle pulse: measurement cancelled

## Operation
- States: IDLE, CLEAR, GATE, WAIT. All outputs are Moore decodes of registered state/sel, except abort_o, which is a registered pulse.
- IDLE:
  - If chan_en_i != 0: load sel with the first enabled channel strictly after last (wrapping N_CH-1 -> 0), then go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR:
  - clr_o=1.
  - Load cnt = (gate_time_i==0) ? 0 : gate_time_i-1. A gate time of 0 is treated as 1.
  - Go to GATE.
- GATE:
  - gate_o=1.
  - If cnt==0, go to WAIT; otherwise decrement cnt.
  - Gate is open for exactly max(gate_time_i,1) cycles.
- WAIT:
  - res_valid_o=1; sel_o stays stable.
  - When res_ready_i=1: last<=sel, go to IDLE.
  - res_valid_o never drops without acceptance.
- Abort:
  - Trigger: chan_en_i[sel] is 0 in CLEAR or GATE.
  - Response: next state is IDLE, abort_o=1 for one cycle, last<=sel. No result is produced, so the faulty channel is skipped next round.
  - Disable during WAIT does not cancel the valid.
- Simultaneous events: a change in chan_en_i affects only the next IDLE pick. gate_time_i changes affect only the next CLEAR.
- Reset values:
  - state=IDLE, sel=0, last=N_CH-1 (so channel 0 is served first), cnt=0.
  - clr_o=0, gate_o=0, res_valid_o=0, abort_o=0.
- Reset mid-operation: all registers return to reset values immediately. gate_o and res_valid_o drop asynchronously.

## Timing
- Latency from IDLE with a channel enabled: clr_o at cycle +1, gate_o cycles +2..+G+1, res_valid_o at +G+2. G = max(gate_time_i,1).
- Per-measurement period with res_ready_i held high: G+3 cycles (IDLE, CLEAR, G×GATE, WAIT).
- Handshake: transfer occurs on a cycle where res_valid_o && res_ready_i. res_ready_i may be high before valid.
- Round-robin fairness: with k channels enabled continuously, each is served once per k measurements.
- cnt is an unsigned GATE_W-bit value and never underflows: the decrement is guarded by cnt!=0.

## Structure
- Shared package dfm_pkg holds:
  - the state enum dfm_sched_state_t (IDLE, CLEAR, GATE, WAIT);
  - DEFAULT_GATE_TIME;
  - N_CH.
- Sub-module rr_pick:
  - combinational next-enabled-channel finder;
  - inputs: req vector, last index;
  - outputs: index, any.
- Everything else (FSM, cnt, last, abort pulse) lives in dfm_gate_sched.

## Test plan
- Single channel: chan_en_i=5'b00100, gate_time_i=4, ready=1 -> sel_o=2, clr_o at +1, gate_o high exactly 4 cycles, res_valid_o 1 cycle, repeats every 7 cycles.
- Round-robin: chan_en_i=5'b01011, gate_time_i=2 -> sel_o order 0,1,3,0,1,3; after reset the first served is 0.
- Zero gate: gate_time_i=0 -> gate_o high exactly 1 cycle, valid at +3.
- Backpressure: ready=0 for 5 cycles in WAIT -> res_valid_o and sel_o stable for 6 cycles, no new clr_o until accept.
- Abort: ch1 measuring with gate_time_i=10, drop chan_en_i[1] at gate cycle 3 -> gate_o falls next cycle, abort_o one pulse, no valid, next served channel is the next enabled after 1.
- Reset mid-gate: assert rst_i during GATE -> gate_o=0 immediately; after release the first measurement is on the lowest enabled channel from 0.

Source files
------------

// File: rtl/dfm_gate_sched_pkg.sv
// Shared types and sizing constants for the frequency-measurement gate scheduler.
package dfm_pkg;

    localparam int unsigned N_CH   = 5;
    localparam int unsigned GATE_W = 32;
    localparam int unsigned SEL_W  = $clog2(N_CH);

    localparam logic [GATE_W-1:0] DEFAULT_GATE_TIME = GATE_W'(16);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GATE  = 2'd2,
        WAIT  = 2'd3
    } dfm_sched_state_t;

endpackage : dfm_pkg

// File: rtl/dfm_gate_sched_if.sv
// Scheduler control/result bus: enables and gate time in, datapath controls and result handshake out.
interface dfm_gate_sched_if;
    import dfm_pkg::*;

    logic [N_CH-1:0]   chan_en_i;
    logic [GATE_W-1:0] gate_time_i;
    logic              res_ready_i;
    logic [SEL_W-1:0]  sel_o;
    logic              clr_o;
    logic              gate_o;
    logic              res_valid_o;
    logic              abort_o;

    // Scheduler side
    modport master (
        input  chan_en_i, gate_time_i, res_ready_i,
        output sel_o, clr_o, gate_o, res_valid_o, abort_o
    );

    // Sequencer / datapath / reader side
    modport slave (
        output chan_en_i, gate_time_i, res_ready_i,
        input  sel_o, clr_o, gate_o, res_valid_o, abort_o
    );

endinterface : dfm_gate_sched_if

// File: rtl/dfm_gate_sched_rr_pick.sv
// Combinational round-robin finder: first requesting channel strictly after i_last, wrapping.
module rr_pick
    import dfm_pkg::*;
(
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_last,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    logic        w_found;
    int unsigned w_cand;

    // Scan offsets 1..N_CH from the last served channel; offset N_CH is last itself
    always_comb begin
        o_idx   = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            w_cand = (32'(i_last) + k) % N_CH;
            if (!w_found && i_req[SEL_W'(w_cand)]) begin
                o_idx   = SEL_W'(w_cand);
                w_found = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/dfm_gate_sched.sv
// Round-robin gate scheduler: clear, gate for G cycles, then hand the result slot downstream.
module dfm_gate_sched
    import dfm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    dfm_gate_sched_if.master  bus
);

    dfm_sched_state_t  r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_sel, w_sel_nxt;
    logic [SEL_W-1:0]  r_last, w_last_nxt;
    logic [GATE_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_abort, w_abort_nxt;
    logic              r_clr, r_gate, r_valid;
    logic              w_clr_nxt, w_gate_nxt, w_valid_nxt;

    logic [SEL_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic              w_sel_en;

    rr_pick u_rr_pick (
        .i_req  (bus.chan_en_i),
        .i_last (r_last),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    assign w_sel_en = bus.chan_en_i[r_sel];

    // State, channel bookkeeping and registered output decodes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= SEL_W'(N_CH - 1);
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_clr   <= 1'b0;
            r_gate  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_abort <= w_abort_nxt;
            r_clr   <= w_clr_nxt;
            r_gate  <= w_gate_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state logic; a disabled channel during CLEAR/GATE aborts and is skipped next round
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_sel_nxt   = w_pick_idx;
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_cnt_nxt = (bus.gate_time_i == '0) ? '0 : bus.gate_time_i - GATE_W'(1);
                if (!w_sel_en) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b1;
                    w_last_nxt  = r_sel;
                end else begin
                    w_state_nxt = GATE;
                end
            end
            GATE: begin
                if (!w_sel_en) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b1;
                    w_last_nxt  = r_sel;
                end else if (r_cnt == '0) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_cnt_nxt = r_cnt - GATE_W'(1);
                end
            end
            WAIT: begin
                if (bus.res_ready_i) begin
                    w_last_nxt  = r_sel;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_clr_nxt   = (w_state_nxt == CLEAR);
        w_gate_nxt  = (w_state_nxt == GATE);
        w_valid_nxt = (w_state_nxt == WAIT);
    end

    assign bus.sel_o       = r_sel;
    assign bus.clr_o       = r_clr;
    assign bus.gate_o      = r_gate;
    assign bus.res_valid_o = r_valid;
    assign bus.abort_o     = r_abort;

endmodule : dfm_gate_sched

// File: tb/tb_dfm_gate_sched.sv
// Randomized bench for dfm_gate_sched against a measurement-timeline reference model.
module tb_dfm_gate_sched;
    import dfm_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    dfm_gate_sched_if u_if ();

    dfm_gate_sched u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (u_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: a measurement is "busy" with an age counted from its CLEAR cycle (age 1)
    bit m_busy;
    int m_age;
    int m_g;
    int m_ch;
    int m_last;
    int m_sel;
    bit m_abort;

    int served_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_after(input logic [N_CH-1:0] en, input int last);
        for (int k = 1; k <= N_CH; k++) begin
            if (en[(last + k) % N_CH]) return (last + k) % N_CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_age   = 0;
        m_g     = 1;
        m_ch    = 0;
        m_last  = N_CH - 1;
        m_sel   = 0;
        m_abort = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic [N_CH-1:0] en;
        en      = u_if.chan_en_i;
        m_abort = 1'b0;
        if (!m_busy) begin
            if (en != '0) begin
                m_ch   = next_after(en, m_last);
                m_sel  = m_ch;
                m_busy = 1'b1;
                m_age  = 1;
            end
        end else if ((m_age == 1 || m_age <= m_g + 1) && !en[m_ch]) begin
            m_busy  = 1'b0;
            m_abort = 1'b1;
            m_last  = m_ch;
        end else if (m_age == 1) begin
            m_g   = (u_if.gate_time_i == 0) ? 1 : int'(u_if.gate_time_i);
            m_age = 2;
        end else if (m_age < m_g + 2) begin
            m_age++;
        end else if (u_if.res_ready_i) begin
            m_busy = 1'b0;
            m_last = m_ch;
        end
    endtask

    task automatic check_outputs();
        chk("sel",   32'(u_if.sel_o),       32'(m_sel));
        chk("clr",   32'(u_if.clr_o),       32'(m_busy && m_age == 1));
        chk("gate",  32'(u_if.gate_o),      32'(m_busy && m_age >= 2 && m_age <= m_g + 1));
        chk("valid", 32'(u_if.res_valid_o), 32'(m_busy && m_age == m_g + 2));
        chk("abort", 32'(u_if.abort_o),     32'(m_abort));
    endtask

    // Called at a falling edge: check, apply new inputs, step model, wait one clock
    task automatic cycle(input logic [N_CH-1:0] en, input int gt, input bit rdy);
        check_outputs();
        if (u_if.clr_o) served_q.push_back(int'(u_if.sel_o));
        u_if.chan_en_i   = en;
        u_if.gate_time_i = GATE_W'(gt);
        u_if.res_ready_i = rdy;
        model_step();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        chk("rst_gate",  32'(u_if.gate_o),      32'd0);
        chk("rst_valid", 32'(u_if.res_valid_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        served_q.delete();
    endtask

    initial begin
        int exp_rr[6];
        int bp_sel;
        int waited;
        logic [N_CH-1:0] en;

        exp_rr = '{0, 1, 3, 0, 1, 3};
        u_if.chan_en_i   = '0;
        u_if.gate_time_i = '0;
        u_if.res_ready_i = 1'b0;
        rst_i            = 1'b1;
        @(negedge clk_i);
        do_reset();
        chk("rst_sel",   32'(u_if.sel_o),   32'd0);
        chk("rst_clr",   32'(u_if.clr_o),   32'd0);
        chk("rst_abort", 32'(u_if.abort_o), 32'd0);

        // Round-robin over channels 0,1,3 straight out of reset
        for (int i = 0; i < 30; i++) cycle(5'b01011, 2, 1'b1);
        for (int i = 0; i < 6; i++) chk("rr_order", 32'(served_q[i]), 32'(exp_rr[i]));

        // Single channel, gate 4, ready held high
        served_q.delete();
        for (int i = 0; i < 30; i++) cycle(5'b00100, 4, 1'b1);
        chk("single_sel", 32'(served_q[0]), 32'd2);

        // Zero gate time
        for (int i = 0; i < 15; i++) cycle(5'b10000, 0, 1'b1);

        // Backpressure: ready low while waiting
        for (int i = 0; i < 12; i++) cycle(5'b00001, 1, 1'b0);
        bp_sel = int'(u_if.sel_o);
        chk("bp_valid", 32'(u_if.res_valid_o), 32'd1);
        for (int i = 0; i < 5; i++) cycle(5'b00011, 1, 1'b0);
        chk("bp_sel_hold", 32'(u_if.sel_o), 32'(bp_sel));
        for (int i = 0; i < 10; i++) cycle(5'b00011, 1, 1'b1);

        // Abort: ch1 with long gate, disabled mid-gate
        do_reset();
        for (int i = 0; i < 3; i++) cycle(5'b00010, 10, 1'b1);
        for (int i = 0; i < 3; i++) cycle(5'b01010, 10, 1'b1);
        cycle(5'b01000, 10, 1'b1);
        chk("abort_pulse", 32'(u_if.abort_o), 32'd1);
        served_q.delete();
        for (int i = 0; i < 10; i++) cycle(5'b01010, 2, 1'b1);
        chk("abort_next", 32'(served_q[0]), 32'd3);

        // Randomized mix with enable churn, backpressure and varied gate times
        en = N_CH'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) en = N_CH'($urandom);
            cycle(en, int'($urandom_range(0, 5)), $urandom_range(0, 3) != 0);
        end

        // Reset while gating; first pick afterwards is lowest enabled from 0
        waited = 0;
        while (!(m_busy && m_age >= 3 && m_age <= m_g + 1) && waited < 60) begin
            cycle(5'b10110, 8, 1'b1);
            waited++;
        end
        chk("gate_reached", 32'(waited < 60), 32'd1);
        chk("pre_rst_gate", 32'(u_if.gate_o), 32'd1);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(5'b10110, 3, 1'b1);
        chk("post_rst_first", 32'(served_q.size() > 0 ? served_q[0] : -1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dfm_gate_sched
